// File: rtl/shift_serializer_pkg.sv
// rtl/shift_serializer_pkg.sv - shared state encoding and width helper for the serializer
// Contents:
//   ser_state_e : FSM states; PARITY is only reachable when SHIFT_SERIALIZER_PARITY_EN is defined
//   cnt_w(dw)   : bit-counter width able to hold 0..dw
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/shift_serializer_if.sv
// rtl/shift_serializer_if.sv - word handshake and serial output bundle of the serializer
// Signals:
//   in_valid/in_ready/in_data : parallel word handshake (producer -> serializer)
//   bit_en                    : bit-slot strobe from the bit-rate divider
//   sout/sout_valid           : serial bit and its live qualifier
//   sout_first/sout_last      : frame markers for the current bit
//   busy                      : a frame is in flight
// Modports: master = producer/observer side, slave = serializer side.
interface shift_serializer_if #(
    parameter int DW = 8
) ();

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          bit_en;
    logic          sout;
    logic          sout_valid;
    logic          sout_first;
    logic          sout_last;
    logic          busy;

    modport master (
        output in_valid,
        output in_data,
        output bit_en,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  sout_first,
        input  sout_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  bit_en,
        output in_ready,
        output sout,
        output sout_valid,
        output sout_first,
        output sout_last,
        output busy
    );

endinterface

// File: rtl/shift_serializer.sv
// rtl/shift_serializer.sv - parallel-in, serial-out transmitter feeding the shift-register link
// Parameters:
//   DW        : word width (>= 2)
//   LSB_FIRST : 0 = MSB first (left shift), 1 = LSB first (right shift)
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : shift_serializer_if.slave (word handshake in, serial bit + markers out)
// Optional build macro SHIFT_SERIALIZER_PARITY_EN appends an even-parity bit slot
// after the DW data bits; sout_last then marks only that parity bit.
module shift_serializer
    import shift_pkg::*;
#(
    parameter int DW        = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_serializer_if.slave bus
);

    localparam int CW = cnt_w(DW);
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    if (DW < 2) begin : g_dw_check
        $error("shift_serializer: DW must be >= 2");
    end

    ser_state_e    state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic accept;
    logic last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
`ifdef SHIFT_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif

        last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

        // The final slot of a frame may hand over directly to the next word,
        // so ready looks at bit_en combinationally to keep frames gapless.
`ifdef SHIFT_SERIALIZER_PARITY_EN
        bus.in_ready = (state_q == IDLE) || ((state_q == PARITY) && bus.bit_en);
`else
        bus.in_ready = (state_q == IDLE) || (last_bit && bus.bit_en);
`endif
        accept = bus.in_valid && bus.in_ready;

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                if (bus.bit_en) begin
                    if (LSB_FIRST != 0) begin
                        shreg_d = {1'b0, shreg_q[DW-1:1]};
                    end else begin
                        shreg_d = {shreg_q[DW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (last_bit) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef SHIFT_SERIALIZER_PARITY_EN
            PARITY: begin
                if (bus.bit_en) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load overrides the end-of-frame transition on the same edge.
        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = bus.in_data;
            cnt_d    = '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_d = ^bus.in_data;
`endif
        end
    end

    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.sout_valid = (state_q != IDLE);
        bus.sout_first = (state_q != IDLE) && (cnt_q == '0);
`ifdef SHIFT_SERIALIZER_PARITY_EN
        bus.sout_last  = (state_q == PARITY);
`else
        bus.sout_last  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif
        bus.sout = 1'b0;
        if (state_q == SHIFT) begin
            bus.sout = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[DW-1];
        end
`ifdef SHIFT_SERIALIZER_PARITY_EN
        else if (state_q == PARITY) begin
            bus.sout = parity_q;
        end
`endif
    end

endmodule

// File: tb/tb_shift_serializer.sv
// tb/tb_shift_serializer.sv - directed and random stimulus for MSB-first and LSB-first serializers
module tb_shift_serializer;

    localparam int DW = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          bit_en   = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;

    int checks = 0;
    int errors = 0;

    // Expected remaining bits of the frame in flight, per bit order.
    bit qm[$];
    bit ql[$];
    int pos = 0;
    int nvalid;

    shift_serializer_if #(.DW(DW)) if_m ();
    shift_serializer_if #(.DW(DW)) if_l ();

    assign if_m.bit_en   = bit_en;
    assign if_m.in_valid = in_valid;
    assign if_m.in_data  = in_data;
    assign if_l.bit_en   = bit_en;
    assign if_l.in_valid = in_valid;
    assign if_l.in_data  = in_data;

    shift_serializer #(.DW(DW), .LSB_FIRST(0)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m)
    );

    shift_serializer #(.DW(DW), .LSB_FIRST(1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void load_frame(input logic [DW-1:0] d);
        qm.delete();
        ql.delete();
        for (int i = DW - 1; i >= 0; i--) qm.push_back(d[i]);
        for (int i = 0; i < DW; i++) ql.push_back(d[i]);
`ifdef SHIFT_SERIALIZER_PARITY_EN
        qm.push_back(^d);
        ql.push_back(^d);
`endif
        pos = 0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "/m_sout"},  if_m.sout,       0);
        check({tag, "/m_valid"}, if_m.sout_valid, 0);
        check({tag, "/m_first"}, if_m.sout_first, 0);
        check({tag, "/m_last"},  if_m.sout_last,  0);
        check({tag, "/m_busy"},  if_m.busy,       0);
        check({tag, "/m_ready"}, if_m.in_ready,   1);
        check({tag, "/l_sout"},  if_l.sout,       0);
        check({tag, "/l_valid"}, if_l.sout_valid, 0);
        check({tag, "/l_ready"}, if_l.in_ready,   1);
    endtask

    // One clock: drive at the falling edge, check mid-low phase, update the model at the rising edge.
    task automatic cyc(input bit be, input bit iv, input logic [DW-1:0] d, input string tag);
        bit live;
        bit exp_ready;
        bit acc;
        bit_en   = be;
        in_valid = iv;
        in_data  = d;
        #1;
        live      = (qm.size() > 0);
        exp_ready = !live || ((qm.size() == 1) && be);
        check({tag, "/m_valid"}, if_m.sout_valid, live);
        check({tag, "/m_busy"},  if_m.busy,       live);
        check({tag, "/m_sout"},  if_m.sout,       live ? qm[0] : 1'b0);
        check({tag, "/m_first"}, if_m.sout_first, live && (pos == 0));
        check({tag, "/m_last"},  if_m.sout_last,  qm.size() == 1);
        check({tag, "/m_ready"}, if_m.in_ready,   exp_ready);
        check({tag, "/l_valid"}, if_l.sout_valid, live);
        check({tag, "/l_sout"},  if_l.sout,       live ? ql[0] : 1'b0);
        check({tag, "/l_first"}, if_l.sout_first, live && (pos == 0));
        check({tag, "/l_last"},  if_l.sout_last,  ql.size() == 1);
        check({tag, "/l_ready"}, if_l.in_ready,   exp_ready);
        acc = iv && exp_ready;
        @(posedge clk);
        if (rst_n) begin
            if (live && be) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
                pos++;
            end
            if (acc) load_frame(d);
        end
        @(negedge clk);
    endtask

    initial begin
        #3;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 0xA5, one bit per cycle
        cyc(1, 1, 8'hA5, "a5_load");
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'h00, "a5_bits");

        // Back-to-back 0x3C then 0xC3 with in_valid held
        cyc(1, 1, 8'h3C, "b2b_load");
        nvalid = 0;
        for (int i = 0; i < 16; i++) begin
            if (if_m.sout_valid === 1'b1) nvalid++;
            cyc(1, (i < 8), 8'hC3, "b2b_bits");
        end
        check("b2b_valid_count", nvalid, 16 + ((DW + 1 - DW) * 0));
        cyc(1, 0, 8'h00, "b2b_idle");

        // Strobe every 4th cycle, intrusion attempt mid-frame
        for (int i = 0; i < 44; i++) begin
            cyc((i % 4) == 3, (i == 0) || (i == 10), (i == 0) ? 8'h81 : 8'h55, "slow");
        end

        // Single set bit exercises bit order on both instances
        cyc(1, 1, 8'h01, "one_load");
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'h00, "one_bits");

        // Async reset after three bits of 0xFF
        cyc(1, 1, 8'hFF, "rst_load");
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00, "rst_bits");
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        qm.delete();
        ql.delete();
        pos = 0;
        @(negedge clk);
        cyc(1, 1, 8'h5A, "in_rst");
        cyc(1, 0, 8'h00, "in_rst");
        rst_n = 1'b1;
        cyc(1, 1, 8'h0F, "post_rst_load");
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'h00, "post_rst_bits");

        // Random strobes, handshakes and data
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                DW'($urandom), "rand");
        end
        for (int i = 0; i < 12; i++) cyc(1, 0, 8'h00, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
Parallel-in, serial-out transmitter. It is the send end of the serial-in/parallel-load shift register link used across the design. It accepts a DW-bit word on a valid/ready handshake and shifts it out one bit per bit_en strobe, MSB-first by default. It drives a bit-valid qualifier and frame markers so the far-end shift register can sample on bit_en while sout_valid is high.

Parameters:
DW, 8, data word width; must be >= 2 (elaboration assertion).
LSB_FIRST, 0, 0 = MSB-first (matches the receiver's left-shift fill); 1 = LSB-first.

Ports:
clk  input  1  clock.
rst_n  input  1  async active-low reset.
in_valid  input  1  in_data holds a word to send.
in_ready  output  1  the serializer can accept a word this cycle.
in_data  input  DW  parallel word.
bit_en  input  1  bit-slot strobe from the bit-rate divider; one bit advances per strobe.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a live bit; the receiver shifts on bit_en && sout_valid.
sout_first  output  1  current bit is the first bit of a frame.
sout_last  output  1  current bit is the final bit of a frame.
busy  output  1  a frame is in flight (state != IDLE).

Behaviour:
- Reset (async, rst_n low): state=IDLE, shreg='0, cnt='0. Outputs: sout=0, sout_valid=0, sout_first=0, sout_last=0, busy=0, in_ready=1.
- Handshake: a word is accepted on a clk edge with in_valid && in_ready. in_data is captured into shreg on that edge. cnt is cleared to 0 and state moves to SHIFT.
- in_ready is combinational: (state==IDLE) || (state==SHIFT && sout_last && bit_en). This gives gapless back-to-back frames: the next word loads on the same edge that consumes the final bit.
- Only in_ready may depend combinationally on bit_en. All other outputs decode registered state.
- sout = shreg[DW-1] if LSB_FIRST==0, otherwise shreg[0]. sout is driven 0 in IDLE.
- sout_valid = busy = (state != IDLE).
- sout_first = sout_valid && cnt==0.
- sout_last = (state==SHIFT && cnt==DW-1) when the parity feature is compiled out.
- SHIFT state, on each bit_en:
  - MSB-first: shreg shifts left with zero fill. LSB-first: shreg shifts right with zero fill.
  - cnt increments.
  - At cnt==DW-1: if a handshake also fires on that edge, reload, cnt=0, stay in SHIFT. Otherwise go to IDLE.
- No bit_en: all state holds; the bit stays on sout indefinitely. in_valid in SHIFT without in_ready is ignored, and the word is not captured.
- cnt width: $clog2(DW+1). cnt never exceeds DW.
- Bit latency: the first bit appears on sout the cycle after acceptance. A frame occupies exactly DW bit_en strobes.
- Reset mid-frame: the frame is aborted immediately, outputs go to reset values, and no partial word is resumed.
- in_data may change after acceptance without affecting the frame.

Optional Feature:
Macro SHIFT_SERIALIZER_PARITY_EN.
- Defined:
  - After the DW data bits, the FSM enters state PARITY for one extra bit slot.
  - In PARITY, sout = even parity (XOR reduction) of the accepted word, latched into a parity register at acceptance.
  - sout_last asserts in PARITY only, not on data bit DW-1.
  - in_ready gapless term becomes (state==PARITY && bit_en).
  - The frame is DW+1 strobes long.
- Undefined: no PARITY state, no parity register; behaviour as above.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] ser_state_e {IDLE, SHIFT, PARITY}. PARITY is present but unused without the macro.
  - function cnt_w(dw) returning $clog2(dw+1).
- No sub-module: the FSM, counter and shift register are small enough to keep inline.

Test Plan:
- Reset then DW=8 MSB-first, send 0xA5 with bit_en every cycle -> sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles. sout_first on bit 0, sout_last on bit 7, then IDLE with in_ready=1.
- Back-to-back 0x3C then 0xC3 with in_valid held -> 16 contiguous valid bits with no gap. The second word is accepted on the edge consuming bit 7 of the first.
- bit_en every 4th cycle, word 0x81 -> each bit held exactly 4 cycles. in_ready stays 0 until the final strobe. A new in_valid mid-frame is not captured.
- LSB_FIRST=1, word 0x01 -> sout=1 on the first bit, then seven 0s.
- rst_n asserted after 3 bits of 0xFF -> outputs go to 0 asynchronously. After release, 0x0F is sent cleanly from bit 0.
- With SHIFT_SERIALIZER_PARITY_EN, word 0x07 -> 8 data bits, then a parity bit of 1. sout_last is on the 9th bit only.
